univ_reg: RTL and testbench
===========================

Name: univ_reg

Overview:
- Parametrised universal register that generalises the single-bit enable/clear flip-flop.
- Adds width, a programmable reset value, a synchronous clear and eight operating modes: hold, load, shift, rotate, increment and decrement.
- Provides registered carry/borrow and zero flags.
- Intended as the building block for the CPU datapath: program counter, accumulator, shift register and loop counters.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RST_VAL, 0, value loaded into q on asynchronous reset; width WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- en  input  1  clock enable; when low, all state holds.
- sclr  input  1  synchronous clear.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for shift modes.
- q  output  WIDTH  register contents.
- cout  output  1  registered carry/borrow/shifted-out bit.
- zero  output  1  registered flag; high when q == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset clr is asynchronous and active-high.
- clr asserted, at any time including mid-operation: immediately sets q = RST_VAL, cout = 0, zero = (RST_VAL == 0). All state holds these values while clr is high.
- Evaluation priority at each rising clk edge: clr > sclr > en > mode.
- sclr = 1, regardless of en: q <= 0, cout <= 0, zero <= 1.
- en = 0 and sclr = 0: q, cout and zero all hold.
- en = 1, sclr = 0, action by mode:
  - 000 HOLD: q holds; cout holds.
  - 001 LOAD: q <= d; cout <= 0.
  - 010 SHL: q <= {q[W-2:0], sin}; cout <= q[W-1].
  - 011 SHR: q <= {sin, q[W-1:1]}; cout <= q[0].
  - 100 ROL: q <= {q[W-2:0], q[W-1]}; cout <= q[W-1].
  - 101 ROR: q <= {q[0], q[W-1:1]}; cout <= q[0].
  - 110 INC: q <= q + 1, modulo 2^W; cout <= 1 only when q was all-ones (wrap to 0), else 0.
  - 111 DEC: q <= q - 1, modulo 2^W; cout <= 1 only when q was 0 (wrap to all-ones), else 0.
- zero flag: updated in the same edge as q, equal to (next q == 0). It is never combinational from q, but zero == (q == 0) must hold at all times outside reset. The assertion checker relies on this invariant.
- Latency: one clock from input to q, cout and zero. No combinational path from inputs to outputs.
- cout is valid for one operation only. It is overwritten by the next enabled non-HOLD operation and keeps its value through HOLD and en = 0.
- Arithmetic is unsigned with WIDTH-bit wrap. There is no saturation.
- sin is ignored in all modes except SHL and SHR. d is ignored in all modes except LOAD.
- Asynchronous reset deassertion is not synchronised inside the block. The top level supplies a synchronised clr release.

Decomposition:
- Shared package (univ_reg_pkg):
  - 3-bit mode constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC.
  - Mode typedef for the datapath decoder.
- One natural sub-module, univ_reg_next: purely combinational next-state logic.
  - Inputs: q, d, sin, mode, cout.
  - Outputs: q_next, cout_next, zero_next.
- The top level holds only the clr/sclr/en register process, so formal properties can target univ_reg_next alone.

Test Plan:
- WIDTH=8, RST_VAL=8'hA5; assert clr mid-cycle while in INC -> q = A5, cout = 0, zero = 0 immediately, without waiting for a clk edge. Release clr; en = 0 for 3 clocks -> q stays A5.
- LOAD d = FF, then INC -> q = 00, cout = 1, zero = 1. Next INC -> q = 01, cout = 0, zero = 0.
- LOAD 00, then DEC -> q = FF, cout = 1, zero = 0. HOLD for 2 clocks -> q = FF, cout stays 1.
- LOAD 81; SHL with sin = 0 -> q = 02, cout = 1. Then SHR with sin = 1 -> q = 81, cout = 0.
- LOAD 81; ROL -> q = 03, cout = 1. Then ROR twice -> q = 81 then C0, cout = 1 then 1.
- With q = 37, sclr = 1, en = 0, mode = INC -> q = 00, cout = 0, zero = 1; sclr overrides en. Next edge with sclr = 0, en = 1, INC -> q = 01.

Source files
------------

// File: rtl/univ_reg_pkg.sv
// univ_reg shared definitions.
// Operating mode encodings for the datapath decoder.
package univ_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  localparam int MODE_W = 3;

endpackage

// File: rtl/univ_reg_if.sv
// univ_reg control/data bundle.
// master drives controls, slave returns register state.
interface univ_reg_if
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic              en;
  logic              sclr;
  logic [MODE_W-1:0] mode;
  logic [WIDTH-1:0]  d;
  logic              sin;
  logic [WIDTH-1:0]  q;
  logic              cout;
  logic              zero;

  modport master (
    output en, sclr, mode, d, sin,
    input  q, cout, zero
  );

  modport slave (
    input  en, sclr, mode, d, sin,
    output q, cout, zero
  );
endinterface

// File: rtl/univ_reg_next.sv
// univ_reg combinational next-state logic.
// Pure function of current state and operands.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  input  logic [MODE_W-1:0] mode,
  input  logic              cout,
  output logic [WIDTH-1:0]  q_next,
  output logic              cout_next,
  output logic              zero_next
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_e w_mode;
  assign w_mode = mode_e'(mode);

  always_comb begin
    q_next    = q;
    cout_next = cout;
    unique case (w_mode)
      MODE_HOLD: begin
        q_next    = q;
        cout_next = cout;
      end
      MODE_LOAD: begin
        q_next    = d;
        cout_next = 1'b0;
      end
      MODE_SHL: begin
        q_next    = {q[WIDTH-2:0], sin};
        cout_next = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next    = {sin, q[WIDTH-1:1]};
        cout_next = q[0];
      end
      MODE_ROL: begin
        q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
        cout_next = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next    = {q[0], q[WIDTH-1:1]};
        cout_next = q[0];
      end
      // carry/borrow flag the wrap-around
      MODE_INC: begin
        q_next    = q + ONE;
        cout_next = &q;
      end
      MODE_DEC: begin
        q_next    = q - ONE;
        cout_next = ~|q;
      end
    endcase
  end

  assign zero_next = (q_next == '0);

endmodule

// File: rtl/univ_reg.sv
// univ_reg: universal register with load/shift/rotate/inc/dec.
// Registered q, carry and zero flag; priority clr > sclr > en.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic        clk,
  input logic        clr,
  univ_reg_if.slave  bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_cout;
  logic             r_zero;

  logic [WIDTH-1:0] w_q_next;
  logic             w_cout_next;
  logic             w_zero_next;

  univ_reg_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q         (r_q),
    .d         (bus.d),
    .sin       (bus.sin),
    .mode      (bus.mode),
    .cout      (r_cout),
    .q_next    (w_q_next),
    .cout_next (w_cout_next),
    .zero_next (w_zero_next)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q    <= RST_VAL;
      r_cout <= 1'b0;
      r_zero <= (RST_VAL == '0);
    end else if (bus.sclr) begin
      r_q    <= '0;
      r_cout <= 1'b0;
      r_zero <= 1'b1;
    end else if (bus.en) begin
      r_q    <= w_q_next;
      r_cout <= w_cout_next;
      r_zero <= w_zero_next;
    end
  end

  assign bus.q    = r_q;
  assign bus.cout = r_cout;
  assign bus.zero = r_zero;

endmodule

// File: tb/tb_univ_reg.sv
// Directed self-checking bench for univ_reg.
// WIDTH=8, RST_VAL=8'hA5.
module tb_univ_reg;
  import univ_reg_pkg::*;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_bad;

  univ_reg_if #(.WIDTH(8)) bus ();

  univ_reg #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic sclr,
                       input mode_e m, input logic [7:0] d,
                       input logic sin);
    bus.en   = en;
    bus.sclr = sclr;
    bus.mode = m;
    bus.d    = d;
    bus.sin  = sin;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    logic [9:0] exp;
    clr = 1'b1;
    drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0);
    #2;
    obs = {bus.q, bus.cout, bus.zero};
    exp = {8'hA5, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_init: got %h want %h", obs, exp);
    end
    step();
    clr = 1'b0;
    drive(1'b1, 1'b0, MODE_INC, 8'h00, 1'b0);
    step();
    step();
    obs = {bus.q, bus.cout, bus.zero};
    exp = {8'hA7, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL inc_before_clr: got %h want %h", obs, exp);
    end
    #2;
    clr = 1'b1;
    #1;
    obs = {bus.q, bus.cout, bus.zero};
    exp = {8'hA5, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL async_clr: got %h want %h", obs, exp);
    end
    step();
    clr = 1'b0;
    drive(1'b0, 1'b0, MODE_INC, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {bus.q, bus.cout, bus.zero};
      exp = {8'hA5, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL en_low_hold%0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_inc_wrap();
    logic [9:0] obs;
    drive(1'b1, 1'b0, MODE_LOAD, 8'hFF, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'hFF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL load_ff: got %h want %h", obs, {8'hFF, 2'b00});
    end
    drive(1'b1, 1'b0, MODE_INC, 8'h5A, 1'b1);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h00, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL inc_wrap: got %h want %h", obs, {8'h00, 2'b11});
    end
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h01, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL inc_after_wrap: got %h want %h", obs, {8'h01, 2'b00});
    end
  endtask

  task automatic test_dec_wrap();
    logic [9:0] obs;
    drive(1'b1, 1'b0, MODE_LOAD, 8'h00, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL load_00: got %h want %h", obs, {8'h00, 2'b01});
    end
    drive(1'b1, 1'b0, MODE_DEC, 8'h33, 1'b1);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'hFF, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL dec_wrap: got %h want %h", obs, {8'hFF, 2'b10});
    end
    drive(1'b1, 1'b0, MODE_HOLD, 8'h12, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      obs = {bus.q, bus.cout, bus.zero};
      n_cmp++;
      if (obs !== {8'hFF, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL hold%0d: got %h want %h", i, obs, {8'hFF, 2'b10});
      end
    end
    drive(1'b0, 1'b0, MODE_LOAD, 8'h12, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'hFF, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL en_low_load: got %h want %h", obs, {8'hFF, 2'b10});
    end
  endtask

  task automatic test_shift();
    logic [9:0] obs;
    drive(1'b1, 1'b0, MODE_LOAD, 8'h81, 1'b1);
    step();
    drive(1'b1, 1'b0, MODE_SHL, 8'h00, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h02, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL shl: got %h want %h", obs, {8'h02, 2'b10});
    end
    drive(1'b1, 1'b0, MODE_SHR, 8'hFF, 1'b1);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h81, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL shr: got %h want %h", obs, {8'h81, 2'b00});
    end
  endtask

  task automatic test_rotate();
    logic [9:0] obs;
    drive(1'b1, 1'b0, MODE_LOAD, 8'h81, 1'b0);
    step();
    drive(1'b1, 1'b0, MODE_ROL, 8'h00, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h03, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL rol: got %h want %h", obs, {8'h03, 2'b10});
    end
    drive(1'b1, 1'b0, MODE_ROR, 8'h00, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h81, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL ror1: got %h want %h", obs, {8'h81, 2'b10});
    end
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'hC0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL ror2: got %h want %h", obs, {8'hC0, 2'b10});
    end
  endtask

  task automatic test_sclr();
    logic [9:0] obs;
    drive(1'b1, 1'b0, MODE_LOAD, 8'h37, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h37, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL load_37: got %h want %h", obs, {8'h37, 2'b00});
    end
    drive(1'b0, 1'b1, MODE_INC, 8'h00, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL sclr: got %h want %h", obs, {8'h00, 2'b01});
    end
    drive(1'b1, 1'b0, MODE_INC, 8'h00, 1'b0);
    step();
    obs = {bus.q, bus.cout, bus.zero};
    n_cmp++;
    if (obs !== {8'h01, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL inc_after_sclr: got %h want %h", obs, {8'h01, 2'b00});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr   = 1'b1;
    drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0);
    test_reset();
    test_inc_wrap();
    test_dec_wrap();
    test_shift();
    test_rotate();
    test_sclr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
